spi_frame_unpacker: RTL and testbench
=====================================

# spi_frame_unpacker

Receive-side stage placed directly downstream of the SPI slave. It captures each completed 512-bit SPI frame and validates its header and checksum. It then streams the payload as addressed 32-bit words over a valid/ready port to the PLL configuration register bank. Frames that arrive while a previous frame is still being processed are counted and dropped.

## Interface
- DATA_WIDTH, 512, frame width; fixed layout below requires 512
- MAGIC, 8'hA5, required header magic byte
- clk  in  1  single clock; all logic on posedge
- rst  in  1  synchronous, active-high reset
- frame_i  in  DATA_WIDTH  received frame (SPI slave data_o)
- frame_valid_i  in  1  one-cycle pulse, frame_i valid (SPI slave r_finish)
- word_o  out  32  payload word
- addr_o  out  8  register address of word_o
- word_valid_o  out  1  word_o/addr_o valid
- word_ready_i  in  1  consumer accepts word this cycle
- busy_o  out  1  state != IDLE
- done_o  out  1  one-cycle pulse, frame fully delivered
- err_o  out  1  one-cycle pulse, frame rejected
- err_code_o  out  2  1=bad magic, 2=bad count, 3=checksum; held until next err_o
- drop_cnt_o  out  8  frames dropped while busy, saturates at 255

## Operation
- Header is frame[511:480]: magic [511:504], count [503:496] (legal 1..15), base [495:488], csum [487:480].
- Payload word k (k=0..14) is frame[479-32k -: 32].
- csum = XOR of all 4 bytes of payload words 0..count-1.
- FSM states are IDLE, CHECK, SEND.
- IDLE + frame_valid_i:
  - Header is checked combinationally on frame_i, with magic checked first and count second.
  - If the header is bad: err_o pulses with the matching code and the state stays IDLE.
  - If the header is good: the frame is captured, k=0, acc=0, and the state goes to CHECK.
- CHECK: one word per cycle, acc ^= byte-XOR(word k), k++.
  - After count cycles, compare acc with csum.
  - Mismatch: err_o pulses with code 3 and the state goes to IDLE.
  - Match: k=0 and the state goes to SEND.
- SEND:
  - word_valid_o=1, word_o=word k, addr_o=base+k (mod 256, wraps).
  - On word_valid_o && word_ready_i, k++.
  - Once word count-1 is accepted, done_o pulses and the state goes to IDLE.
- frame_valid_i while not in IDLE, including the cycle the FSM returns to IDLE: the frame is dropped and drop_cnt_o increments, saturating at 255.
- word_valid_o never deasserts and word_o/addr_o never change until the word is accepted.

## Timing
- Reset values: word_o=0, addr_o=0, word_valid_o=0, busy_o=0, done_o=0, err_o=0, err_code_o=0, drop_cnt_o=0, state IDLE.
- Reset during CHECK/SEND discards the captured frame, and no done_o/err_o is issued.
- Frame pulse at cycle T, header bad: err_o=1 at T+1, busy_o stays 0.
- Frame pulse at T, header good:
  - busy_o=1 from T+1.
  - CHECK runs T+1..T+count.
  - Either err_o or the first word_valid_o appears at T+count+1.
- SEND with word_ready_i tied high: one word per cycle.
- Last word accepted at cycle S:
  - done_o=1 and busy_o=0 at S+1.
  - A new frame is accepted at S+1, since the FSM is in IDLE.
- done_o and err_o are registered and never asserted together.

## Structure
- Package spi_frame_pkg contains:
  - header field offsets and the payload word offset function;
  - the state enum (IDLE/CHECK/SEND);
  - the err_code enum;
  - a byte_xor32 function.
- No sub-module: a single module holds the capture register, k counter, acc, FSM and drop counter.

## Test plan
- count=2, base=8'h10, words 32'h11223344, 32'h00000001, header 32'hA5021045, ready high:
  - word_valid_o at T+3;
  - addr/word 10/11223344 then 11/00000001;
  - done_o at T+5.
- Same frame with csum=8'h46: err_o at T+3, err_code_o=3, no word_valid_o.
- magic 8'h5A gives err_code_o=1 at T+1. Count 0 and count 16 give err_code_o=2.
- base=8'hFF, count=2: addr_o sequence FF then 00.
- word_ready_i toggled 0/1 each cycle: word_o/addr_o stay stable while stalled, and all words are delivered in order.
- Three frame_valid_i pulses during CHECK/SEND give drop_cnt_o=3; 300 such pulses give drop_cnt_o=255.
- rst mid-SEND: all outputs return to reset values the next cycle, and a following valid frame is processed normally.

Source files
------------

// File: rtl/spi_frame_pkg.sv
// Shared types and helpers for the SPI frame unpacker: frame layout, FSM states,
// error codes and payload/checksum helpers.
package spi_frame_pkg;

   localparam int unsigned FRAME_W   = 512;
   localparam int unsigned HDR_W     = 32;
   localparam int unsigned WORD_W    = 32;
   localparam int unsigned ADDR_W    = 8;
   localparam int unsigned MAX_WORDS = 15;
   localparam int unsigned WORD0_LSB = FRAME_W - HDR_W - WORD_W;

   // Header occupies the top 32 bits of the frame, magic in the MSB byte.
   typedef struct packed {
      logic [7:0] magic;
      logic [7:0] count;
      logic [7:0] base;
      logic [7:0] csum;
   } hdr_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CHECK = 2'd1,
      ST_SEND  = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      ERR_NONE  = 2'd0,
      ERR_MAGIC = 2'd1,
      ERR_COUNT = 2'd2,
      ERR_CSUM  = 2'd3
   } err_code_t;

   // LSB position of payload word k; word 0 sits directly below the header.
   function automatic int unsigned word_lsb(input logic [3:0] k);
      return WORD0_LSB - (32'(k) << 5);
   endfunction

   function automatic logic [WORD_W-1:0] payload_word(input logic [FRAME_W-1:0] f,
                                                      input logic [3:0] k);
      logic [FRAME_W-1:0] s;
      s = f >> word_lsb(k);
      return s[WORD_W-1:0];
   endfunction

   function automatic logic [7:0] byte_xor32(input logic [31:0] w);
      return w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
   endfunction

endpackage

// File: rtl/spi_frame_unpacker.sv
// Validates completed SPI frames (magic, count, checksum) and streams the payload
// as addressed 32-bit words over valid/ready; frames arriving while busy are dropped.
module spi_frame_unpacker
   import spi_frame_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = FRAME_W,
   parameter logic [7:0]  MAGIC      = 8'hA5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] frame_i,
   input  logic                  frame_valid_i,
   output logic [31:0]           word_o,
   output logic [7:0]            addr_o,
   output logic                  word_valid_o,
   input  logic                  word_ready_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  err_o,
   output logic [1:0]            err_code_o,
   output logic [7:0]            drop_cnt_o
);

   state_t                state_q, state_d;
   logic [DATA_WIDTH-1:0] frame_q, frame_d;
   logic [3:0]            k_q, k_d;
   logic [7:0]            acc_q, acc_d;
   logic [31:0]           word_d;
   logic [7:0]            addr_d;
   logic                  valid_d, busy_d, done_d, err_d;
   err_code_t             code_q, code_d;
   logic [7:0]            drop_d;

   hdr_t                  in_hdr, cap_hdr;
   logic                  last_c;
   logic [7:0]            acc_nxt_c;
   logic [31:0]           cur_word_c, next_word_c;

   assign in_hdr      = hdr_t'(frame_i[DATA_WIDTH-1 -: HDR_W]);
   assign cap_hdr     = hdr_t'(frame_q[DATA_WIDTH-1 -: HDR_W]);
   assign last_c      = (8'(k_q) == (cap_hdr.count - 8'd1));
   assign cur_word_c  = payload_word(frame_q, k_q);
   assign next_word_c = payload_word(frame_q, k_q + 4'd1);
   assign err_code_o  = code_q;

   // Next-state and next-output logic.
   always_comb begin
      state_d   = state_q;
      frame_d   = frame_q;
      k_d       = k_q;
      acc_d     = acc_q;
      word_d    = word_o;
      addr_d    = addr_o;
      valid_d   = word_valid_o;
      busy_d    = busy_o;
      done_d    = 1'b0;
      err_d     = 1'b0;
      code_d    = code_q;
      drop_d    = drop_cnt_o;
      acc_nxt_c = acc_q ^ byte_xor32(cur_word_c);

      case (state_q)
         ST_IDLE: begin
            if (frame_valid_i) begin
               if (in_hdr.magic != MAGIC) begin
                  err_d  = 1'b1;
                  code_d = ERR_MAGIC;
               end else if (in_hdr.count == 8'd0 || in_hdr.count > 8'(MAX_WORDS)) begin
                  err_d  = 1'b1;
                  code_d = ERR_COUNT;
               end else begin
                  frame_d = frame_i;
                  k_d     = 4'd0;
                  acc_d   = 8'd0;
                  busy_d  = 1'b1;
                  state_d = ST_CHECK;
               end
            end
         end

         // One payload word folded into the checksum per cycle.
         ST_CHECK: begin
            if (last_c) begin
               if (acc_nxt_c != cap_hdr.csum) begin
                  err_d   = 1'b1;
                  code_d  = ERR_CSUM;
                  busy_d  = 1'b0;
                  state_d = ST_IDLE;
               end else begin
                  k_d     = 4'd0;
                  valid_d = 1'b1;
                  word_d  = payload_word(frame_q, 4'd0);
                  addr_d  = cap_hdr.base;
                  state_d = ST_SEND;
               end
            end else begin
               k_d   = k_q + 4'd1;
               acc_d = acc_nxt_c;
            end
         end

         ST_SEND: begin
            if (word_ready_i) begin
               if (last_c) begin
                  valid_d = 1'b0;
                  done_d  = 1'b1;
                  busy_d  = 1'b0;
                  state_d = ST_IDLE;
               end else begin
                  k_d    = k_q + 4'd1;
                  word_d = next_word_c;
                  addr_d = cap_hdr.base + 8'(k_q) + 8'd1;
               end
            end
         end

         default: begin
            valid_d = 1'b0;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
      endcase

      if (frame_valid_i && state_q != ST_IDLE && drop_cnt_o != 8'hFF)
         drop_d = drop_cnt_o + 8'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         frame_q      <= '0;
         k_q          <= 4'd0;
         acc_q        <= 8'd0;
         word_o       <= 32'd0;
         addr_o       <= 8'd0;
         word_valid_o <= 1'b0;
         busy_o       <= 1'b0;
         done_o       <= 1'b0;
         err_o        <= 1'b0;
         code_q       <= ERR_NONE;
         drop_cnt_o   <= 8'd0;
      end else begin
         state_q      <= state_d;
         frame_q      <= frame_d;
         k_q          <= k_d;
         acc_q        <= acc_d;
         word_o       <= word_d;
         addr_o       <= addr_d;
         word_valid_o <= valid_d;
         busy_o       <= busy_d;
         done_o       <= done_d;
         err_o        <= err_d;
         code_q       <= code_d;
         drop_cnt_o   <= drop_d;
      end
   end

endmodule

// File: tb/tb_spi_frame_unpacker.sv
// Self-checking bench for spi_frame_unpacker: transaction-level reference model
// compared every cycle, plus directed literal checks and randomized traffic.
module tb_spi_frame_unpacker;

   logic         clk = 1'b0;
   logic         rst;
   logic [511:0] frame_i;
   logic         frame_valid_i;
   logic [31:0]  word_o;
   logic [7:0]   addr_o;
   logic         word_valid_o;
   logic         word_ready_i;
   logic         busy_o;
   logic         done_o;
   logic         err_o;
   logic [1:0]   err_code_o;
   logic [7:0]   drop_cnt_o;

   always #5 clk = ~clk;

   spi_frame_unpacker dut (
      .clk           (clk),
      .rst           (rst),
      .frame_i       (frame_i),
      .frame_valid_i (frame_valid_i),
      .word_o        (word_o),
      .addr_o        (addr_o),
      .word_valid_o  (word_valid_o),
      .word_ready_i  (word_ready_i),
      .busy_o        (busy_o),
      .done_o        (done_o),
      .err_o         (err_o),
      .err_code_o    (err_code_o),
      .drop_cnt_o    (drop_cnt_o)
   );

   int n_vec  = 0;
   int n_miss = 0;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endfunction

   // Reference model: phase 0 idle, 1 validating, 2 delivering.
   int          m_phase;
   int          m_left;
   bit          m_ok;
   bit          m_rz;
   bit          m_done, m_err;
   logic [1:0]  m_code;
   int          m_drop;
   logic [31:0] mq_word[$];
   logic [7:0]  mq_addr[$];

   logic [31:0] pw[15];

   function automatic logic [31:0] fword(input logic [511:0] f, input int i);
      logic [511:0] s;
      s = f >> (448 - 32 * i);
      return s[31:0];
   endfunction

   function automatic logic [7:0] bx(input logic [31:0] w);
      return w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
   endfunction

   function automatic logic [7:0] csum_of(input int cnt);
      logic [7:0] x;
      x = 8'd0;
      for (int i = 0; i < cnt && i < 15; i++) x ^= bx(pw[i]);
      return x;
   endfunction

   function automatic logic [511:0] mk(input logic [7:0] mg, input logic [7:0] cnt,
                                       input logic [7:0] base, input logic [7:0] cs);
      logic [511:0] f;
      f = 512'({mg, cnt, base, cs});
      for (int i = 0; i < 15; i++) f = (f << 32) | 512'(pw[i]);
      return f;
   endfunction

   function automatic void model_edge(input bit r, input bit fv, input logic [511:0] f, input bit rdy);
      int pre;
      logic [7:0] mg, cnt, base, cs, x;
      pre    = m_phase;
      m_done = 1'b0;
      m_err  = 1'b0;
      if (r) begin
         m_phase = 0; m_code = 2'd0; m_drop = 0; m_rz = 1'b1;
         mq_word.delete(); mq_addr.delete();
         return;
      end
      case (pre)
         0: if (fv) begin
            mg = f[511:504]; cnt = f[503:496]; base = f[495:488]; cs = f[487:480];
            if (mg != 8'hA5) begin
               m_err = 1'b1; m_code = 2'd1;
            end else if (cnt == 8'd0 || cnt > 8'd15) begin
               m_err = 1'b1; m_code = 2'd2;
            end else begin
               x = 8'd0;
               for (int i = 0; i < int'(cnt); i++) begin
                  x ^= bx(fword(f, i));
                  mq_word.push_back(fword(f, i));
                  mq_addr.push_back(8'(int'(base) + i));
               end
               m_ok    = (x == cs);
               m_left  = int'(cnt);
               m_phase = 1;
            end
         end
         1: begin
            m_left--;
            if (m_left == 0) begin
               if (!m_ok) begin
                  m_err = 1'b1; m_code = 2'd3; m_phase = 0;
                  mq_word.delete(); mq_addr.delete();
               end else begin
                  m_phase = 2; m_rz = 1'b0;
               end
            end
         end
         default: if (rdy) begin
            void'(mq_word.pop_front());
            void'(mq_addr.pop_front());
            if (mq_word.size() == 0) begin
               m_done = 1'b1; m_phase = 0;
            end
         end
      endcase
      if (pre != 0 && fv && m_drop < 255) m_drop++;
   endfunction

   function automatic void compare_all();
      chk("busy", 32'(busy_o), 32'(m_phase != 0));
      chk("done", 32'(done_o), 32'(m_done));
      chk("err", 32'(err_o), 32'(m_err));
      chk("err_code", 32'(err_code_o), 32'(m_code));
      chk("drop_cnt", 32'(drop_cnt_o), 32'(m_drop));
      chk("word_valid", 32'(word_valid_o), 32'(m_phase == 2));
      if (m_phase == 2) begin
         chk("word", word_o, mq_word[0]);
         chk("addr", 32'(addr_o), 32'(mq_addr[0]));
      end else if (m_rz) begin
         chk("word_rst", word_o, 32'd0);
         chk("addr_rst", 32'(addr_o), 32'd0);
      end
   endfunction

   task automatic step(input bit r, input bit fv, input logic [511:0] f, input bit rdy);
      rst = r; frame_valid_i = fv; frame_i = f; word_ready_i = rdy;
      @(posedge clk);
      model_edge(r, fv, f, rdy);
      #1;
      compare_all();
   endtask

   task automatic idle(input int n, input bit rdy);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, rdy);
   endtask

   function automatic logic [511:0] rand_frame();
      logic [7:0] mg, cnt, cs;
      int r;
      for (int i = 0; i < 15; i++) pw[i] = $urandom;
      mg  = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'hA5;
      r   = $urandom_range(0, 19);
      cnt = (r <= 15) ? 8'(r) : 8'($urandom_range(16, 255));
      cs  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : csum_of(int'(cnt));
      return mk(mg, cnt, 8'($urandom), cs);
   endfunction

   logic [511:0] f;

   initial begin
      rst = 1'b1; frame_valid_i = 1'b0; frame_i = '0; word_ready_i = 1'b0;
      m_phase = 0; m_left = 0; m_ok = 1'b0; m_rz = 1'b1; m_done = 1'b0; m_err = 1'b0;
      m_code = 2'd0; m_drop = 0;

      // Reset state
      step(1'b1, 1'b0, '0, 1'b0);
      step(1'b1, 1'b0, '0, 1'b0);
      chk("lit_rst_busy", 32'(busy_o), 32'd0);
      chk("lit_rst_valid", 32'(word_valid_o), 32'd0);
      chk("lit_rst_word", word_o, 32'd0);
      chk("lit_rst_drop", 32'(drop_cnt_o), 32'd0);

      // Reference frame: count 2, base 10, csum 45
      for (int i = 0; i < 15; i++) pw[i] = $urandom;
      pw[0] = 32'h11223344; pw[1] = 32'h00000001;
      f = mk(8'hA5, 8'h02, 8'h10, 8'h45);
      step(1'b0, 1'b1, f, 1'b1);
      chk("lit_t1_busy", 32'(busy_o), 32'd1);
      idle(2, 1'b1);
      chk("lit_t3_valid", 32'(word_valid_o), 32'd1);
      chk("lit_t3_addr", 32'(addr_o), 32'h10);
      chk("lit_t3_word", word_o, 32'h11223344);
      idle(1, 1'b1);
      chk("lit_t4_addr", 32'(addr_o), 32'h11);
      chk("lit_t4_word", word_o, 32'h00000001);
      idle(1, 1'b1);
      chk("lit_t5_done", 32'(done_o), 32'd1);
      chk("lit_t5_busy", 32'(busy_o), 32'd0);

      // Same frame, wrong checksum
      f = mk(8'hA5, 8'h02, 8'h10, 8'h46);
      step(1'b0, 1'b1, f, 1'b1);
      idle(2, 1'b1);
      chk("lit_cs_err", 32'(err_o), 32'd1);
      chk("lit_cs_code", 32'(err_code_o), 32'd3);
      chk("lit_cs_valid", 32'(word_valid_o), 32'd0);
      idle(1, 1'b1);

      // Header rejections
      step(1'b0, 1'b1, mk(8'h5A, 8'h02, 8'h10, 8'h45), 1'b1);
      chk("lit_magic_err", 32'(err_o), 32'd1);
      chk("lit_magic_code", 32'(err_code_o), 32'd1);
      chk("lit_magic_busy", 32'(busy_o), 32'd0);
      step(1'b0, 1'b1, mk(8'hA5, 8'h00, 8'h10, 8'h00), 1'b1);
      chk("lit_cnt0_code", 32'(err_code_o), 32'd2);
      step(1'b0, 1'b1, mk(8'hA5, 8'h10, 8'h10, 8'h00), 1'b1);
      chk("lit_cnt16_code", 32'(err_code_o), 32'd2);
      idle(1, 1'b1);

      // Address wrap
      for (int i = 0; i < 15; i++) pw[i] = $urandom;
      step(1'b0, 1'b1, mk(8'hA5, 8'h02, 8'hFF, csum_of(2)), 1'b1);
      idle(2, 1'b1);
      chk("lit_wrap_ff", 32'(addr_o), 32'hFF);
      idle(1, 1'b1);
      chk("lit_wrap_00", 32'(addr_o), 32'h00);
      idle(2, 1'b1);

      // Alternating ready on a full 15-word frame
      for (int i = 0; i < 15; i++) pw[i] = $urandom;
      step(1'b0, 1'b1, mk(8'hA5, 8'd15, 8'h40, csum_of(15)), 1'b0);
      for (int i = 0; i < 60; i++) step(1'b0, 1'b0, '0, 1'(i % 2));

      // Drop counting and saturation
      step(1'b1, 1'b0, '0, 1'b0);
      for (int i = 0; i < 15; i++) pw[i] = $urandom;
      step(1'b0, 1'b1, mk(8'hA5, 8'd4, 8'h20, csum_of(4)), 1'b0);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, rand_frame(), 1'b0);
      chk("lit_drop3", 32'(drop_cnt_o), 32'd3);
      for (int i = 0; i < 300; i++) step(1'b0, 1'b1, rand_frame(), 1'b0);
      chk("lit_drop_sat", 32'(drop_cnt_o), 32'd255);

      // Reset while stalled in SEND, then a normal frame
      step(1'b1, 1'b0, '0, 1'b0);
      chk("lit_mid_busy", 32'(busy_o), 32'd0);
      chk("lit_mid_valid", 32'(word_valid_o), 32'd0);
      chk("lit_mid_addr", 32'(addr_o), 32'd0);
      chk("lit_mid_drop", 32'(drop_cnt_o), 32'd0);
      chk("lit_mid_code", 32'(err_code_o), 32'd0);
      for (int i = 0; i < 15; i++) pw[i] = $urandom;
      step(1'b0, 1'b1, mk(8'hA5, 8'd3, 8'h80, csum_of(3)), 1'b1);
      idle(8, 1'b1);

      // Randomized traffic
      for (int i = 0; i < 4000; i++) begin
         bit r, fv, rdy;
         r   = ($urandom_range(0, 499) == 0);
         fv  = ($urandom_range(0, 11) == 0);
         rdy = ($urandom_range(0, 9) < 7);
         step(r, fv, fv ? rand_frame() : 512'(0), rdy);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
